uart_rx_oversampler: RTL and testbench

UART receive front end that consumes the 16x `baud_clock` tick from the UART clock generator and recovers serial frames from the `rx` line. It synchronises `rx`, detects start bits, majority-votes three mid-bit samples per bit, and checks parity and stop. Completed characters go into a single holding register with status flags for the APB register layer. It sits directly downstream of the clock generator, in parallel with the transmitter that consumes `xmit_pulse`.

---
 rtl/uart_rx_oversampler.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampler.sv
// UART receive front end: rx synchroniser, 16x oversampled start/data/parity/stop
// recovery with 3-sample majority vote, and a single holding register with status flags.
module uart_rx_oversampler #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_clock,
   input  logic       rx,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       read_ack,
   output logic [7:0] rx_data,
   output logic       data_ready,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overflow,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t     state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic       rx_s;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic       s7_q, s7_d, s8_q, s8_d;
   logic       armed_q, armed_d;
   logic       cfg_bit8_q, cfg_bit8_d, cfg_par_q, cfg_par_d, cfg_odd_q, cfg_odd_d;
   logic       perr_q, perr_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       data_ready_q, data_ready_d;
   logic       parity_err_q, parity_err_d;
   logic       framing_err_q, framing_err_d;
   logic       overflow_q, overflow_d;
   logic       busy_q, busy_d;
   logic       vote_c, ferr_c, commit_c;
   logic [2:0] last_idx_c;

   assign rx_s = sync_q[SYNC_STAGES-1];

   // rx synchroniser, idles high out of reset
   always_ff @(posedge clk) begin
      if (reset) sync_q <= '1;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         bit_idx_q     <= 3'd0;
         shift_q       <= 8'd0;
         s7_q          <= 1'b1;
         s8_q          <= 1'b1;
         armed_q       <= 1'b0;
         cfg_bit8_q    <= 1'b1;
         cfg_par_q     <= 1'b0;
         cfg_odd_q     <= 1'b0;
         perr_q        <= 1'b0;
         rx_data_q     <= 8'd0;
         data_ready_q  <= 1'b0;
         parity_err_q  <= 1'b0;
         framing_err_q <= 1'b0;
         overflow_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         s7_q          <= s7_d;
         s8_q          <= s8_d;
         armed_q       <= armed_d;
         cfg_bit8_q    <= cfg_bit8_d;
         cfg_par_q     <= cfg_par_d;
         cfg_odd_q     <= cfg_odd_d;
         perr_q        <= perr_d;
         rx_data_q     <= rx_data_d;
         data_ready_q  <= data_ready_d;
         parity_err_q  <= parity_err_d;
         framing_err_q <= framing_err_d;
         overflow_q    <= overflow_d;
         busy_q        <= busy_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      s7_d          = s7_q;
      s8_d          = s8_q;
      armed_d       = armed_q;
      cfg_bit8_d    = cfg_bit8_q;
      cfg_par_d     = cfg_par_q;
      cfg_odd_d     = cfg_odd_q;
      perr_d        = perr_q;
      rx_data_d     = rx_data_q;
      data_ready_d  = data_ready_q;
      parity_err_d  = parity_err_q;
      framing_err_d = framing_err_q;
      overflow_d    = overflow_q;
      ferr_c        = 1'b0;
      commit_c      = 1'b0;
      vote_c        = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
      last_idx_c    = cfg_bit8_q ? 3'd7 : 3'd6;

      if (baud_clock) begin
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == 4'd7) s7_d = rx_s;
         if (cnt_q == 4'd8) s8_d = rx_s;
         unique case (state_q)
            IDLE: begin
               // detection tick counts as cnt = 0, so the next tick sees cnt = 1
               cnt_d = 4'd0;
               if (rx_s) begin
                  armed_d = 1'b1;
               end else if (armed_q) begin
                  state_d    = START;
                  cnt_d      = 4'd1;
                  armed_d    = 1'b0;
                  shift_d    = 8'd0;
                  perr_d     = 1'b0;
                  cfg_bit8_d = bit8;
                  cfg_par_d  = parity_en;
                  cfg_odd_d  = odd_n_even;
               end
            end
            START: begin
               if (cnt_q == 4'd9 && vote_c) state_d = IDLE;
               else if (cnt_q == 4'd15) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end
            end
            DATA: begin
               if (cnt_q == 4'd9) shift_d[bit_idx_q] = vote_c;
               if (cnt_q == 4'd15) begin
                  if (bit_idx_q == last_idx_c) state_d = cfg_par_q ? PARITY : STOP;
                  else bit_idx_d = bit_idx_q + 3'd1;
               end
            end
            PARITY: begin
               if (cnt_q == 4'd9 && (vote_c != ((^shift_q) ^ cfg_odd_q))) perr_d = 1'b1;
               if (cnt_q == 4'd15) state_d = STOP;
            end
            STOP: begin
               if (cnt_q == 4'd9) begin
                  ferr_c   = ~vote_c;
                  commit_c = 1'b1;
                  state_d  = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // holding register: a read_ack in the commit cycle frees the slot for the new frame
      if (commit_c && (!data_ready_q || read_ack)) begin
         rx_data_d     = shift_q;
         data_ready_d  = 1'b1;
         parity_err_d  = perr_q;
         framing_err_d = ferr_c;
         if (read_ack) overflow_d = 1'b0;
      end else if (commit_c) begin
         overflow_d = 1'b1;
      end else if (read_ack) begin
         data_ready_d  = 1'b0;
         parity_err_d  = 1'b0;
         framing_err_d = 1'b0;
         overflow_d    = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   assign rx_data     = rx_data_q;
   assign data_ready  = data_ready_q;
   assign parity_err  = parity_err_q;
   assign framing_err = framing_err_q;
   assign overflow    = overflow_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: table of frames plus hand-written
// glitch, break, overflow, simultaneous read/commit and mid-frame reset sequences.
module tb_uart_rx_oversampler;

   logic       clk = 1'b0;
   logic       reset, baud_clock, rx, bit8, parity_en, odd_n_even, read_ack;
   logic [7:0] rx_data;
   logic       data_ready, parity_err, framing_err, overflow, busy;

   int n_checks = 0;
   int n_pass   = 0;

   uart_rx_oversampler #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
      .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
      .read_ack(read_ack), .rx_data(rx_data), .data_ready(data_ready),
      .parity_err(parity_err), .framing_err(framing_err),
      .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   // 16x tick on every 4th clk, so one bit is 64 clk
   initial begin
      logic [1:0] div;
      div = 2'd0;
      baud_clock = 1'b0;
      forever begin
         @(negedge clk);
         baud_clock = (div == 2'd3);
         div = div + 2'd1;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] data;
      logic       b8;
      logic       pen;
      logic       odd;
      logic       par_good;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                             input logic pbit, input logic sb);
      rx = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         rx = d[i];
         repeat (64) @(negedge clk);
      end
      if (pen) begin
         rx = pbit;
         repeat (64) @(negedge clk);
      end
      rx = sb;
      repeat (64) @(negedge clk);
      rx = 1'b1;
   endtask

   // wait for busy, then count ticks until data_ready rises (or until stop_at ticks)
   task automatic watch(input int stop_at, output int ticks, output bit ok);
      int guard;
      bit b;
      ticks = 0;
      ok    = 1'b0;
      guard = 0;
      while (busy !== 1'b1 && guard < 2000) begin
         @(posedge clk); #1; guard++;
      end
      if (busy !== 1'b1) return;
      guard = 0;
      while (guard < 4000) begin
         @(posedge clk);
         b = baud_clock;
         #1;
         guard++;
         if (b) ticks++;
         if (stop_at == 0 && data_ready === 1'b1) begin ok = 1'b1; return; end
         if (stop_at != 0 && ticks == stop_at) begin ok = 1'b1; return; end
      end
   endtask

   task automatic pulse_ack();
      @(negedge clk); read_ack = 1'b1;
      @(negedge clk); read_ack = 1'b0;
   endtask

   initial begin
      int         t, nb, exp_t;
      bit         ok, saw_busy;
      logic [7:0] mask;
      logic       pbit;

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h35, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h35, 1'b0, 1'b0};
      vecs[2] = '{8'h35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h35, 1'b1, 1'b0};
      vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
      vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};
      vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};

      reset = 1'b1; rx = 1'b1; bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0; read_ack = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      check("reset_rx_data", 32'(rx_data), 32'h0);
      check("reset_data_ready", 32'(data_ready), 32'h0);
      check("reset_parity_err", 32'(parity_err), 32'h0);
      check("reset_framing_err", 32'(framing_err), 32'h0);
      check("reset_overflow", 32'(overflow), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      repeat (40) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         bit8 = vecs[v].b8; parity_en = vecs[v].pen; odd_n_even = vecs[v].odd;
         nb    = vecs[v].b8 ? 8 : 7;
         mask  = vecs[v].b8 ? 8'hFF : 8'h7F;
         pbit  = (^(vecs[v].data & mask)) ^ vecs[v].odd ^ ~vecs[v].par_good;
         exp_t = 16 * (1 + nb + (vecs[v].pen ? 1 : 0)) + 9;
         fork
            send_frame(vecs[v].data, nb, vecs[v].pen, pbit, vecs[v].stop);
            watch(0, t, ok);
         join
         check($sformatf("v%0d_commit_seen", v), 32'(ok), 32'h1);
         check($sformatf("v%0d_ticks", v), 32'(t), 32'(exp_t));
         check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
         check($sformatf("v%0d_parity_err", v), 32'(parity_err), 32'(vecs[v].exp_perr));
         check($sformatf("v%0d_framing_err", v), 32'(framing_err), 32'(vecs[v].exp_ferr));
         check($sformatf("v%0d_overflow", v), 32'(overflow), 32'h0);
         pulse_ack();
         check($sformatf("v%0d_ack_data_ready", v), 32'(data_ready), 32'h0);
         check($sformatf("v%0d_ack_flags", v), 32'({parity_err, framing_err}), 32'h0);
         repeat (32) @(negedge clk);
      end
      bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;

      // short low glitch: false start
      saw_busy = 1'b0;
      rx = 1'b0;
      repeat (12) begin @(negedge clk); if (busy) saw_busy = 1'b1; end
      rx = 1'b1;
      repeat (100) begin @(negedge clk); if (busy) saw_busy = 1'b1; end
      check("glitch_saw_busy", 32'(saw_busy), 32'h1);
      check("glitch_busy_after", 32'(busy), 32'h0);
      check("glitch_data_ready", 32'(data_ready), 32'h0);

      // continuous break yields one frame only
      rx = 1'b0;
      watch(0, t, ok);
      check("break_commit_seen", 32'(ok), 32'h1);
      check("break_rx_data", 32'(rx_data), 32'h0);
      check("break_framing_err", 32'(framing_err), 32'h1);
      pulse_ack();
      repeat (700) @(negedge clk);
      check("break_no_second_frame", 32'(data_ready), 32'h0);
      check("break_busy", 32'(busy), 32'h0);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      check("break_release_idle", 32'(data_ready), 32'h0);

      // overflow: second frame discarded
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
      repeat (100) @(negedge clk);
      check("ovf_data_ready", 32'(data_ready), 32'h1);
      check("ovf_rx_data", 32'(rx_data), 32'h11);
      check("ovf_overflow", 32'(overflow), 32'h1);
      pulse_ack();
      check("ovf_ack_clear", 32'({data_ready, overflow, parity_err, framing_err}), 32'h0);

      // read_ack in the same clk as a commit while overflow is set
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
      repeat (40) @(negedge clk);
      check("sim_pre_overflow", 32'(overflow), 32'h1);
      fork
         send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
         begin
            int g;
            watch(152, t, ok);
            check("sim_reached_tick152", 32'(ok), 32'h1);
            g = 0;
            do begin @(negedge clk); #1; g++; end while (!baud_clock && g < 10);
            read_ack = 1'b1;
            @(posedge clk); #1;
            read_ack = 1'b0;
         end
      join
      check("sim_rx_data", 32'(rx_data), 32'h22);
      check("sim_data_ready", 32'(data_ready), 32'h1);
      check("sim_overflow", 32'(overflow), 32'h0);
      pulse_ack();
      repeat (40) @(negedge clk);

      // reset during data bit 4, then a clean frame
      rx = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = (8'h5A >> i) & 8'h01;
         repeat (64) @(negedge clk);
      end
      rx = 1'b1;
      repeat (32) @(negedge clk);
      check("rst_busy_before", 32'(busy), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_busy_after", 32'(busy), 32'h0);
      check("rst_data_ready", 32'(data_ready), 32'h0);
      repeat (100) @(negedge clk);
      fork
         send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
         watch(0, t, ok);
      join
      check("rst_next_commit", 32'(ok), 32'h1);
      check("rst_next_ticks", 32'(t), 32'd153);
      check("rst_next_rx_data", 32'(rx_data), 32'h5A);
      check("rst_next_flags", 32'({parity_err, framing_err, overflow}), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
